// File: rtl/prc_copy.sv
// prc_copy -- copies one PRC frame from the system-RAM framebuffer to the LCD.
//
// Every page starts with three command bytes (page address 0xB0|page, then
// column high 0x10 and column low 0x00). These are followed by COLUMNS display
// bytes. Each display byte is fetched with a held read request, latched on
// mem_ack, and then written to the LCD as data (a0=1).
//
// Optional feature: define PRC_COPY_INVERT_EN to add an 'invert' input. It is
// sampled together with start, and when it is set every display byte of that
// frame is written bit-inverted. With the macro undefined there is no invert
// port and bytes are copied unmodified.
//
// Timing with zero-wait memory and a permanently ready LCD:
//   - each page costs 3 command cycles plus 3 cycles per byte;
//   - the 3 cycles per byte are: read issue, read acknowledge, LCD data write;
//   - one further DONE cycle follows the last write.
module prc_copy #(
    parameter logic [23:0] FB_BASE = 24'h001000,
    parameter int          COLUMNS = 96,
    parameter int          PAGES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef PRC_COPY_INVERT_EN
    input  logic        invert,
`endif
    output logic        busy,
    output logic        done,
    output logic [23:0] mem_address,
    output logic        mem_read,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data_in,
    input  logic        lcd_ready,
    output logic        lcd_write,
    output logic        lcd_a0,
    output logic [7:0]  lcd_data
);

    // Copy sequencer states
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PAGE_CMD = 3'd1;
    localparam logic [2:0] S_COLH_CMD = 3'd2;
    localparam logic [2:0] S_COLL_CMD = 3'd3;
    localparam logic [2:0] S_RD_REQ   = 3'd4;
    localparam logic [2:0] S_WR_DATA  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    // LCD command opcodes
    localparam logic [7:0] CMD_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COLH = 8'h10;
    localparam logic [7:0] CMD_COLL = 8'h00;

    // Terminal counter values, narrowed to the counter widths
    localparam logic [6:0] LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);

    logic [2:0]  r_state;
    logic [2:0]  r_page;
    logic [6:0]  r_col;
    logic        r_mem_read;
    logic [23:0] r_mem_address;
    logic [7:0]  r_byte;
    logic [23:0] w_rd_address;
    logic [7:0]  w_out_byte;
    logic        w_ack_take;
    logic        w_last_col;
    logic        w_last_page;
`ifdef PRC_COPY_INVERT_EN
    logic        r_invert;
`endif

    // Framebuffer address of the current (page, column), kept in 24 bits
    assign w_rd_address = FB_BASE
                        + (24'(r_page) * 24'(COLUMNS))
                        + 24'(r_col);

    // An acknowledge only counts while our own request is outstanding,
    // so a stray or late mem_ack after a reset is ignored.
    assign w_ack_take  = (r_state == S_RD_REQ) && r_mem_read && mem_ack;

    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_page = (r_page == LAST_PAGE);

    // Byte presented on the LCD bus during a data write
`ifdef PRC_COPY_INVERT_EN
    assign w_out_byte = r_invert ? ~r_byte : r_byte;
`else
    assign w_out_byte = r_byte;
`endif

    // Sequencer: state, page/column counters and the held read request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_page        <= 3'd0;
            r_col         <= 7'd0;
            r_mem_read    <= 1'b0;
            r_mem_address <= 24'd0;
`ifdef PRC_COPY_INVERT_EN
            r_invert      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // start is only looked at here, so a request while busy is dropped
                    if (start) begin
                        r_page  <= 3'd0;
                        r_col   <= 7'd0;
`ifdef PRC_COPY_INVERT_EN
                        r_invert <= invert;
`endif
                        r_state <= S_PAGE_CMD;
                    end
                end
                S_PAGE_CMD: begin
                    if (lcd_ready) begin
                        r_state <= S_COLH_CMD;
                    end
                end
                S_COLH_CMD: begin
                    if (lcd_ready) begin
                        r_state <= S_COLL_CMD;
                    end
                end
                S_COLL_CMD: begin
                    if (lcd_ready) begin
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    // First cycle raises the request with a registered address.
                    // Address and request then stay frozen until the acknowledge arrives.
                    if (!r_mem_read) begin
                        r_mem_read    <= 1'b1;
                        r_mem_address <= w_rd_address;
                    end else if (mem_ack) begin
                        r_mem_read <= 1'b0;
                        r_state    <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (lcd_ready) begin
                        if (!w_last_col) begin
                            r_col   <= r_col + 7'd1;
                            r_state <= S_RD_REQ;
                        end else if (!w_last_page) begin
                            r_col   <= 7'd0;
                            r_page  <= r_page + 3'd1;
                            r_state <= S_PAGE_CMD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-data holding register; pure datapath, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_ack_take) begin
            r_byte <= mem_data_in;
        end
    end

    // Output decode. The LCD strobe is gated directly by lcd_ready, so it can
    // never fire while the LCD is not ready. mem_read is low in every state
    // that writes to the LCD.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        lcd_write = 1'b0;
        lcd_a0    = 1'b0;
        lcd_data  = 8'h00;
        case (r_state)
            S_PAGE_CMD: begin
                lcd_write = lcd_ready;
                lcd_data  = CMD_PAGE | {5'b00000, r_page};
            end
            S_COLH_CMD: begin
                lcd_write = lcd_ready;
                lcd_data  = CMD_COLH;
            end
            S_COLL_CMD: begin
                lcd_write = lcd_ready;
                lcd_data  = CMD_COLL;
            end
            S_WR_DATA: begin
                lcd_write = lcd_ready;
                lcd_a0    = 1'b1;
                lcd_data  = w_out_byte;
            end
            default: begin
                lcd_write = 1'b0;
            end
        endcase
    end

    assign mem_read    = r_mem_read;
    assign mem_address = r_mem_address;

endmodule

// File: tb/tb_prc_copy.sv
// tb_prc_copy -- scoreboard bench for prc_copy.
// Expected LCD writes and expected read addresses are queued whenever a frame
// is started; an independent negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_prc_copy;

    localparam logic [23:0] FB     = 24'h001000;
    localparam int          COLS   = 96;
    localparam int          PGS    = 8;
    localparam int          NBYTES = COLS * PGS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        lcd_ready = 1'b1;
    logic        busy, done, mem_read, mem_ack, lcd_write, lcd_a0;
    logic [23:0] mem_address;
    logic [7:0]  mem_data_in, lcd_data;
`ifdef PRC_COPY_INVERT_EN
    logic        invert = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0]  lcd_q[$];
    logic [23:0] addr_q[$];
    logic [7:0]  mem [0:NBYTES-1];

    int          rd_cnt = 0;
    int          need;
    int          idx;
    bit          delay_on = 1'b0;
    int          done_cnt = 0;
    int          rd5_cnt = 0;
    logic        prev_rd = 1'b0;
    logic        prev_ack = 1'b0;
    logic [23:0] prev_addr = 24'd0;

    always #5 clk = ~clk;

    prc_copy #(.FB_BASE(FB), .COLUMNS(COLS), .PAGES(PGS)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef PRC_COPY_INVERT_EN
        .invert(invert),
`endif
        .busy(busy),
        .done(done),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_ack(mem_ack),
        .mem_data_in(mem_data_in),
        .lcd_ready(lcd_ready),
        .lcd_write(lcd_write),
        .lcd_a0(lcd_a0),
        .lcd_data(lcd_data)
    );

    // RAM model: same-cycle data, optional 3-cycle ack delay at FB+5
    always_comb begin
        idx = int'(mem_address) - int'(FB);
        mem_data_in = 8'h00;
        if (idx >= 0 && idx < NBYTES) mem_data_in = mem[idx];
        need = (delay_on && mem_address == FB + 24'd5) ? 3 : 0;
        mem_ack = mem_read && (rd_cnt >= need);
    end

    always @(posedge clk) begin
        if (reset || !mem_read || mem_ack) rd_cnt <= 0;
        else rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol rules plus scoreboard pops
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_read && mem_address == FB + 24'd5) rd5_cnt++;
        if (mem_read && prev_rd && !prev_ack) chk("rd_addr_stable", mem_address, prev_addr);
        prev_rd   = mem_read;
        prev_ack  = mem_ack;
        prev_addr = mem_address;
        if (mem_read && mem_ack) begin
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected actual=%0h expected=none", mem_address);
            end else begin
                chk("rd_addr", mem_address, addr_q.pop_front());
            end
        end
        if (lcd_write) begin
            chk("wr_while_ready", lcd_ready, 1);
            chk("wr_no_mem_read", mem_read, 0);
            if (lcd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL lcd_unexpected actual=%0h expected=none", {lcd_a0, lcd_data});
            end else begin
                chk("lcd_byte", {lcd_a0, lcd_data}, lcd_q.pop_front());
            end
        end
    end

    task automatic push_frame(input bit inv);
        for (int p = 0; p < PGS; p++) begin
            lcd_q.push_back({1'b0, 8'hB0 | 8'(p)});
            lcd_q.push_back({1'b0, 8'h10});
            lcd_q.push_back({1'b0, 8'h00});
            for (int c = 0; c < COLS; c++) begin
                addr_q.push_back(FB + 24'(p * COLS + c));
                lcd_q.push_back({1'b1, inv ? ~mem[p * COLS + c] : mem[p * COLS + c]});
            end
        end
    endtask

    // Issues one start and counts cycles from the start cycle to done
    task automatic run_frame(input bit inv, input int extra_at, output int n);
        push_frame(inv);
`ifdef PRC_COPY_INVERT_EN
        invert = inv;
`endif
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++; #1;
            start = (n == extra_at);
`ifdef PRC_COPY_INVERT_EN
            invert = 1'b0;
`endif
            @(negedge clk);
        end while (!done && n < 5000);
    endtask

    task automatic check_queues(input string tag);
        chk({tag, "_lcd_q_empty"}, lcd_q.size(), 0);
        chk({tag, "_addr_q_empty"}, addr_q.size(), 0);
    endtask

    initial begin
        int n;
        int d0;
        int k;
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'(i * 37 + 11);
        mem[2]  = 8'h0F;
        mem[96] = 8'hA5;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_lcd_write", lcd_write, 0);
        chk("rst_lcd_a0", lcd_a0, 0);
        chk("rst_lcd_data", lcd_data, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Frame 1: zero-wait memory, LCD always ready
        run_frame(1'b0, 0, n);
        chk("f1_cycles_to_done", n, 2329);
        @(posedge clk); @(negedge clk);
        chk("f1_busy_after_done", busy, 0);
        chk("f1_done_one_cycle", done, 0);
        check_queues("f1");

        // Frame 2: delayed ack at column 5, LCD stall on column 10 data
        @(posedge clk); #1;
        push_frame(1'b0);
        delay_on = 1'b1;
        rd5_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!(mem_read && mem_ack && mem_address == FB + 24'd10) && k < 2000);
        chk("f2_reach_col10", (k < 2000), 1);
        lcd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk("stall_no_write", lcd_write, 0);
            chk("stall_data_held", {lcd_a0, lcd_data}, {1'b1, mem[10]});
        end
        @(posedge clk); #1 lcd_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!done && k < 3000);
        chk("f2_done_seen", done, 1);
        chk("f2_col5_read_cycles", rd5_cnt, 4);
        delay_on = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("f2_busy_after_done", busy, 0);
        check_queues("f2");

        // Frame 3: second start while busy must be ignored
        @(posedge clk); #1;
        d0 = done_cnt;
        run_frame(1'b0, 100, n);
        chk("f3_cycles_to_done", n, 2329);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("f3_single_done", done_cnt - d0, 1);
        chk("f3_idle", busy, 0);
        check_queues("f3");

        // Frame 4: reset at cycle 500 abandons the copy
        @(posedge clk); #1;
        push_frame(1'b0);
        start = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1 start = 1'b0;
        end
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        lcd_q.delete();
        addr_q.delete();
        @(negedge clk);
        chk("f4_rst_busy", busy, 0);
        chk("f4_rst_mem_read", mem_read, 0);
        chk("f4_rst_mem_address", mem_address, 0);
        chk("f4_rst_lcd_write", lcd_write, 0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("f4_no_done", done_cnt - d0, 0);
        chk("f4_still_idle", busy, 0);

        // Frame 5: recovery after reset (with inversion when built in)
        @(posedge clk); #1;
`ifdef PRC_COPY_INVERT_EN
        run_frame(1'b1, 0, n);
`else
        run_frame(1'b0, 0, n);
`endif
        chk("f5_cycles_to_done", n, 2329);
        @(posedge clk); @(negedge clk);
        chk("f5_busy_after_done", busy, 0);
        check_queues("f5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prc_copy.md
PRC_COPY -- requirements
Module: prc_copy

Interface
REQ-001 SHALL have parameter FB_BASE, default 24'h001000, meaning framebuffer base address in system RAM.
REQ-002 SHALL have parameter COLUMNS, default 96, meaning bytes per LCD page.
REQ-003 SHALL have parameter PAGES, default 8, meaning LCD pages per frame.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port start  input  1  copy request pulse from PRC frame sequencer.
REQ-007 SHALL have port busy  output  1  high while a copy is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a copy completes.
REQ-009 SHALL have port mem_address  output  24  framebuffer read address.
REQ-010 SHALL have port mem_read  output  1  read request, held until acknowledged.
REQ-011 SHALL have port mem_ack  input  1  read acknowledge; mem_data_in valid in the same cycle.
REQ-012 SHALL have port mem_data_in  input  8  read data.
REQ-013 SHALL have port lcd_ready  input  1  LCD controller can accept a write this cycle.
REQ-014 SHALL have port lcd_write  output  1  one-cycle LCD write strobe.
REQ-015 SHALL have port lcd_a0  output  1  0 = command byte, 1 = display data byte.
REQ-016 SHALL have port lcd_data  output  8  LCD write byte.

Function
REQ-017 SHALL implement states IDLE, PAGE_CMD, COLH_CMD, COLL_CMD, RD_REQ, WR_DATA, DONE.
REQ-018 SHALL, in IDLE with start=1, clear page and column counters and enter PAGE_CMD the next cycle; start while busy SHALL be ignored.
REQ-019 SHALL, in PAGE_CMD, wait for lcd_ready=1, then pulse lcd_write with lcd_a0=0, lcd_data=8'hB0|page, and advance to COLH_CMD.
REQ-020 SHALL, in COLH_CMD, issue command 8'h10 on lcd_ready, then COLL_CMD issue 8'h00 on lcd_ready, then enter RD_REQ.
REQ-021 SHALL, in RD_REQ, drive mem_read=1 and mem_address=FB_BASE+page*COLUMNS+column, held stable until mem_ack=1.
REQ-022 SHALL latch mem_data_in on the mem_ack cycle, drop mem_read the next cycle, and enter WR_DATA.
REQ-023 SHALL, in WR_DATA, on lcd_ready=1 pulse lcd_write with lcd_a0=1 and the latched byte.
REQ-024 SHALL after each data write: column<COLUMNS-1 -> column+1, RD_REQ; column=COLUMNS-1 and page<PAGES-1 -> column=0, page+1, PAGE_CMD; last byte -> DONE.
REQ-025 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-026 SHALL hold busy=1 in every state except IDLE; busy SHALL fall in the cycle following done.
REQ-027 SHALL never assert lcd_write while lcd_ready=0 and never assert lcd_write and mem_read in the same cycle.
REQ-028 SHALL compute mem_address in 24 bits; page counter 3 bits, column counter 7 bits.
REQ-029 SHALL, with zero-wait mem_ack and lcd_ready constantly 1, complete a default frame in 8*(3+96*3)+1 = 2329 cycles from start to done.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, enter IDLE and drive busy=0, done=0, mem_read=0, mem_address=0, lcd_write=0, lcd_a0=0, lcd_data=0, counters=0.
REQ-031 SHALL abandon an in-progress copy on reset without emitting done; any outstanding read is dropped and a late mem_ack ignored.

Configuration
REQ-032 SHALL, with macro PRC_COPY_INVERT_EN defined, add input invert (1 bit) sampled at start and write ~byte for every data byte of that frame.
REQ-033 SHALL, without PRC_COPY_INVERT_EN, have no invert port and write framebuffer bytes unmodified.

Verification
REQ-034 SHALL cover: reset, start pulse, zero-wait memory, lcd_ready=1 -> first writes B0,10,00 (a0=0), 768 data bytes, done at cycle 2329, busy low next cycle.
REQ-035 SHALL cover: RAM byte at 24'h001060 = 8'hA5 -> written as first data byte after command 8'hB1.
REQ-036 SHALL cover: mem_ack delayed 3 cycles on column 5 -> mem_address 24'h001005 and mem_read held stable 4 cycles, no lcd_write meanwhile.
REQ-037 SHALL cover: lcd_ready low 10 cycles during WR_DATA -> no strobe, data held, single write when ready returns.
REQ-038 SHALL cover: second start while busy -> ignored, exactly one done; reset at cycle 500 -> IDLE, no done.
REQ-039 SHALL cover (PRC_COPY_INVERT_EN): invert=1 at start, RAM byte 8'h0F -> LCD data 8'hF0.
